// File: rtl/me_search_ctrl.sv
// Motion-estimation search sequencer: issues NUM_CAND candidate indices, tracks the minimum SAD returned PIPE_LAT cycles later.
// Latency start->done is NUM_CAND+PIPE_LAT+2 cycles with cur_ready high; WAIT_CUR stalls indefinitely on cur_ready, start while busy is dropped.
module me_search_ctrl #(
    parameter int NUM_CAND = 49,
    parameter int PIPE_LAT = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cur_ready,
    input  logic [20:0] res_in,
    output logic [5:0]  sr_addressRead,
    output logic        issue_valid,
    output logic        busy,
    output logic [12:0] best_sad,
    output logic [7:0]  best_addr,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CUR,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_CAND - 1);

    state_t              state;
    logic [PIPE_LAT-1:0] vld_sr;
    logic                cmp_valid;
    logic [3:0]          drain_cnt;
    logic [12:0]         run_sad;
    logic [7:0]          run_addr;
    logic [12:0]         run_sad_nxt;
    logic [7:0]          run_addr_nxt;

    assign cmp_valid = vld_sr[PIPE_LAT-1];

    // Strict less-than so ties keep the earlier candidate.
    always_comb begin
        run_sad_nxt  = run_sad;
        run_addr_nxt = run_addr;
        if (cmp_valid && (res_in[20:8] < run_sad)) begin
            run_sad_nxt  = res_in[20:8];
            run_addr_nxt = res_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            vld_sr         <= '0;
            drain_cnt      <= '0;
            run_sad        <= 13'h1FFF;
            run_addr       <= 8'h00;
            sr_addressRead <= '0;
            issue_valid    <= 1'b0;
            busy           <= 1'b0;
            best_sad       <= 13'h1FFF;
            best_addr      <= 8'h00;
            done           <= 1'b0;
        end else begin
            vld_sr   <= (vld_sr << 1) | PIPE_LAT'(issue_valid);
            run_sad  <= run_sad_nxt;
            run_addr <= run_addr_nxt;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WAIT_CUR;
                        busy  <= 1'b1;
                    end
                end
                WAIT_CUR: begin
                    if (cur_ready) begin
                        state          <= ISSUE;
                        issue_valid    <= 1'b1;
                        sr_addressRead <= '0;
                        run_sad        <= 13'h1FFF;
                        run_addr       <= 8'h00;
                    end
                end
                ISSUE: begin
                    if (sr_addressRead == LAST_IDX) begin
                        state       <= DRAIN;
                        issue_valid <= 1'b0;
                        drain_cnt   <= 4'(PIPE_LAT);
                    end else begin
                        sr_addressRead <= sr_addressRead + 6'd1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 4'd1;
                    // The last result is compared on this same edge, so publish the merged value.
                    if (drain_cnt == 4'd1) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        best_sad  <= run_sad_nxt;
                        best_addr <= run_addr_nxt;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    issue_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl with a behavioural PIPE_LAT-deep SAD datapath model.
module tb_me_search_ctrl;

    localparam int LAT = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cur_ready;
    logic [20:0] res_in;
    logic [5:0]  sr_addressRead;
    logic        issue_valid;
    logic        busy;
    logic [12:0] best_sad;
    logic [7:0]  best_addr;
    logic        done;

    me_search_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cur_ready      (cur_ready),
        .res_in         (res_in),
        .sr_addressRead (sr_addressRead),
        .issue_valid    (issue_valid),
        .busy           (busy),
        .best_sad       (best_sad),
        .best_addr      (best_addr),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ia;
        logic [12:0] sa;
        logic [7:0]  aa;
        logic [6:0]  ib;
        logic [12:0] sb;
        logic [7:0]  ab;
        logic [12:0] def_sad;
        logic [12:0] exp_sad;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs [0:5];
    vec_t cfg;

    int total = 0;
    int bad   = 0;

    // Datapath model: index issued in cycle k comes back on res_in in cycle k+LAT.
    logic [5:0] p_idx [0:LAT-1];
    logic       p_v   [0:LAT-1];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            p_idx[i] <= p_idx[i-1];
            p_v[i]   <= p_v[i-1];
        end
        p_idx[0] <= sr_addressRead;
        p_v[0]   <= issue_valid;
    end

    always @(negedge clk) begin
        if (p_v[LAT-1] === 1'b1) begin
            if ({1'b0, p_idx[LAT-1]} == cfg.ia)
                res_in = {cfg.sa, cfg.aa};
            else if ({1'b0, p_idx[LAT-1]} == cfg.ib)
                res_in = {cfg.sb, cfg.ab};
            else
                res_in = {cfg.def_sad, 8'h80 + {2'b00, p_idx[LAT-1]}};
        end else begin
            // Out-of-window garbage that would win every comparison if not masked.
            res_in = {13'd0, 8'hEE};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_search(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int cyc;
    int n_done;
    int guard;

    initial begin
        vecs[0] = '{7'd20, 13'd37, 8'h6A, 7'd127, 13'd0,  8'h00, 13'd100,   13'd37,    8'h6A};
        vecs[1] = '{7'd5,  13'd0,  8'h11, 7'd30,  13'd0,  8'h2C, 13'd100,   13'd0,     8'h11};
        vecs[2] = '{7'd127, 13'd0, 8'h00, 7'd127, 13'd0,  8'h00, 13'd500,   13'd500,   8'h80};
        vecs[3] = '{7'd48, 13'd1,  8'h55, 7'd127, 13'd0,  8'h00, 13'h1FFE,  13'd1,     8'h55};
        vecs[4] = '{7'd0,  13'd5,  8'h33, 7'd1,   13'd5,  8'h44, 13'd900,   13'd5,     8'h33};
        vecs[5] = '{7'd127, 13'd0, 8'h00, 7'd127, 13'd0,  8'h00, 13'h1FFF,  13'h1FFF,  8'h00};

        cfg       = vecs[0];
        rst_n     = 1'b0;
        start     = 1'b0;
        cur_ready = 1'b1;
        res_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_done",  32'(done),           32'd0);
        chk("rst_ivld",  32'(issue_valid),    32'd0);
        chk("rst_addr",  32'(sr_addressRead), 32'd0);
        chk("rst_bsad",  32'(best_sad),       32'h1FFF);
        chk("rst_baddr", 32'(best_addr),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            cfg = vecs[v];
            run_search(cyc);
            chk($sformatf("v%0d_latency", v), 32'(cyc),       32'd58);
            chk($sformatf("v%0d_sad", v),     32'(best_sad),  32'(vecs[v].exp_sad));
            chk($sformatf("v%0d_addr", v),    32'(best_addr), 32'(vecs[v].exp_addr));
            @(negedge clk);
            chk($sformatf("v%0d_pulse", v),   32'(done),      32'd0);
        end

        // Stall in WAIT_CUR.
        cfg       = vecs[0];
        cur_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_ivld", 32'(issue_valid), 32'd0);
            chk("stall_busy", 32'(busy),        32'd1);
            if (i < 9) @(negedge clk);
        end
        cur_ready = 1'b1;
        @(negedge clk);
        chk("stall_issue", 32'(issue_valid),    32'd1);
        chk("stall_idx0",  32'(sr_addressRead), 32'd0);
        guard = 0;
        while (!done && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("stall_done", 32'(done),     32'd1);
        chk("stall_sad",  32'(best_sad), 32'd37);

        // Second start during ISSUE must be dropped.
        cfg = vecs[1];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        for (int i = 1; i < 150; i++) begin
            if (i == 20) start = 1'b1;
            if (i == 21) start = 1'b0;
            if (done) n_done++;
            @(negedge clk);
        end
        chk("ign_ndone", 32'(n_done),    32'd1);
        chk("ign_busy",  32'(busy),      32'd0);
        chk("ign_addr",  32'(best_addr), 32'h11);

        // Reset while issuing index 12.
        cfg = vecs[0];
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(issue_valid && sr_addressRead == 6'd12) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("rstm_reach", 32'(sr_addressRead), 32'd12);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstm_busy", 32'(busy),        32'd0);
        chk("rstm_ivld", 32'(issue_valid), 32'd0);
        chk("rstm_bsad", 32'(best_sad),    32'h1FFF);
        n_done = 0;
        for (int i = 0; i < 70; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        chk("rstm_nodone", 32'(n_done), 32'd0);
        run_search(cyc);
        chk("rstm_latency", 32'(cyc),       32'd58);
        chk("rstm_sad",     32'(best_sad),  32'd37);
        chk("rstm_addr",    32'(best_addr), 32'h6A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/me_search_ctrl.md
ME_SEARCH_CTRL -- requirements
Module: me_search_ctrl

Interface
REQ-001 Parameter NUM_CAND, default 49, number of candidate positions issued per search (7x7 window), legal 1..64.
REQ-002 Parameter PIPE_LAT, default 7, cycles from a candidate index on sr_addressRead to its SAD result on res_in, legal 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a search for the current block.
REQ-006 cur_ready  input  1  current-block rows cur_b0..cur_b3 stable and valid.
REQ-007 res_in  input  21  SAD-datapath result: [20:8] SAD (13 b, zero-extended), [7:0] encoded candidate address.
REQ-008 sr_addressRead  output  6  candidate index driven to the datapath.
REQ-009 issue_valid  output  1  sr_addressRead carries a live candidate this cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 best_sad  output  13  minimum SAD of the last completed search.
REQ-012 best_addr  output  8  res_in[7:0] captured with best_sad.
REQ-013 done  output  1  one-cycle pulse: best_sad/best_addr final.

Function
REQ-014 FSM states SHALL be IDLE, WAIT_CUR, ISSUE, DRAIN, DONE.
REQ-015 IDLE: start=1 -> WAIT_CUR; start otherwise ignored.
REQ-016 WAIT_CUR: cur_ready=1 -> ISSUE in next cycle; otherwise hold indefinitely.
REQ-017 ISSUE: issue_valid=1; sr_addressRead = counter, 0 on entry, +1 per cycle; counter = NUM_CAND-1 -> DRAIN.
REQ-018 DRAIN: down-counter loaded with PIPE_LAT on entry; reaching 0 -> DONE.
REQ-019 DONE: done=1 for exactly one cycle, then IDLE.
REQ-020 sr_addressRead SHALL hold its last value outside ISSUE; issue_valid=0 outside ISSUE.
REQ-021 A PIPE_LAT-deep shift register SHALL delay issue_valid; its output tap (cmp_valid) marks res_in as belonging to the current search.
REQ-022 On entry to ISSUE, running minimum SHALL initialise to 13'h1FFF, running address to 8'h00.
REQ-023 When cmp_valid=1 and res_in[20:8] < running minimum (strict), running minimum/address SHALL take res_in[20:8]/res_in[7:0] next cycle; ties keep the earlier candidate.
REQ-024 res_in SHALL be ignored when cmp_valid=0.
REQ-025 best_sad/best_addr SHALL update only on the DONE cycle (copied from running registers) and hold until the next DONE.
REQ-026 Exactly NUM_CAND comparisons per search; total start-to-done latency = 1 (WAIT_CUR, cur_ready already high) + NUM_CAND + PIPE_LAT + 1 cycles.
REQ-027 start asserted while busy=1 SHALL be ignored (no queueing).
REQ-028 Counters SHALL not wrap: ISSUE counter width 6 b, terminal at NUM_CAND-1; no index >= NUM_CAND is ever issued.

Reset
REQ-029 rst_n=0 at a clock edge SHALL, regardless of state: FSM -> IDLE, sr_addressRead=0, issue_valid=0, busy=0, done=0, best_sad=13'h1FFF, best_addr=0, delay line cleared, running minimum 13'h1FFF.
REQ-030 Reset mid-search SHALL discard the search; no done pulse and no best_* update for it.

Verification
REQ-031 Basic: NUM_CAND=49, PIPE_LAT=7, cur_ready=1, start pulse, res_in SAD = 100 for all but candidate 20 (SAD 37, addr 8'h6A) -> done at cycle 58 after start, best_sad=37, best_addr=8'h6A.
REQ-032 Tie: candidates 5 and 30 both SAD 0 (addr 8'h11, 8'h2C) -> best_addr=8'h11.
REQ-033 Stall: start with cur_ready=0 for 10 cycles -> issue_valid stays 0, busy=1; issue begins cycle after cur_ready=1.
REQ-034 Ignore: second start during ISSUE -> single done pulse; FSM returns to IDLE; best_* from first search only.
REQ-035 Reset mid-ISSUE at index 12 -> next cycle busy=0, best_sad=13'h1FFF, no done; new start completes normally.
REQ-036 Garbage outside window: res_in = SAD 0 while cmp_valid=0, all valid SADs = 500 -> best_sad=500.
